// File: rtl/pc_unit_pkg.sv
// Shared program-counter definitions: reset/increment defaults and the next-PC
// source encoding that the control unit also uses.
package pc_unit_pkg;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned PC_INSTR_BYTES  = 32'd4;
  localparam int unsigned PC_RAS_DEPTH    = 32'd4;

  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_JMP  = 3'd2;
  localparam logic [2:0] NPC_CALL = 3'd3;
  localparam logic [2:0] NPC_RET  = 3'd4;

  // Lower-priority requests are dropped entirely when a higher one is present.
  function automatic logic [2:0] npc_select(input logic ret, input logic call,
                                            input logic jump, input logic branch);
    logic [2:0] sel;
    if (ret) begin
      sel = NPC_RET;
    end else if (call) begin
      sel = NPC_CALL;
    end else if (jump) begin
      sel = NPC_JMP;
    end else if (branch) begin
      sel = NPC_BR;
    end else begin
      sel = NPC_SEQ;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the control unit (master) and the PC unit (slave).
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF_W  = 8
);

  logic              stall;
  logic              branch;
  logic              jump;
  logic              call;
  logic              ret;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pcout;
  logic [ADDR_W-1:0] pcnext;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output stall, branch, jump, call, ret, offset, target,
    input  pcout, pcnext, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch, jump, call, ret, offset, target,
    output pcout, pcnext, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/pc_unit_ras.sv
// Circular return-address stack: pushing when full overwrites the oldest entry,
// popping when empty leaves state alone; both set a sticky error flag.
module pc_unit_ras
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = PC_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              err_o
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  // ptr_q is the next free slot, so the top of stack sits one below it.
  assign top_o   = mem_q[ptr_q - PTR_W'(1)];
  assign empty_o = (cnt_q == {CNT_W{1'b0}});
  assign full_o  = (cnt_q == CNT_MAX);
  assign err_o   = err_q;

  // Pointer, occupancy and error next-state.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (pop_i) begin
      if (empty_o) begin
        err_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full_o) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Stack bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_i && !pop_i) begin
      mem_q[ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, branch adder, prioritised next-PC mux and
// return-address stack for call/return flows.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       OFF_W        = 8,
  parameter int unsigned       INSTR_BYTES  = PC_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
  parameter int unsigned       RAS_DEPTH    = PC_RAS_DEPTH
) (
  input logic       clk,
  input logic       rst_n,
  pc_unit_if.slave  bus
);

  localparam int unsigned       SHIFT = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(INSTR_BYTES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] seq_s, br_s, off_s, ras_top_s;
  logic [2:0]        sel_s;
  logic              push_s, pop_s;
  logic              ras_empty_s, ras_full_s, ras_err_s;

  // Offset counts instructions, so scale it to bytes after sign extension.
  assign seq_s  = pc_q + INC;
  assign off_s  = ADDR_W'($signed(bus.offset)) << SHIFT;
  assign br_s   = seq_s + off_s;
  assign sel_s  = npc_select(bus.ret, bus.call, bus.jump, bus.branch);
  assign push_s = !bus.stall && (sel_s == NPC_CALL);
  assign pop_s  = !bus.stall && (sel_s == NPC_RET);

  // Next-PC source mux.
  always_comb begin
    pc_d = seq_s;
    case (sel_s)
      NPC_RET:  pc_d = ras_empty_s ? seq_s : ras_top_s;
      NPC_CALL: pc_d = bus.target;
      NPC_JMP:  pc_d = bus.target;
      NPC_BR:   pc_d = br_s;
      NPC_SEQ:  pc_d = seq_s;
      default:  pc_d = seq_s;
    endcase
  end

  // PC register; stall freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else if (!bus.stall) begin
      pc_q <= pc_d;
    end
  end

  pc_unit_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .push_data_i (seq_s),
    .top_o       (ras_top_s),
    .empty_o     (ras_empty_s),
    .full_o      (ras_full_s),
    .err_o       (ras_err_s)
  );

  assign bus.pcout     = pc_q;
  assign bus.pcnext    = seq_s;
  assign bus.ras_empty = ras_empty_s;
  assign bus.ras_full  = ras_full_s;
  assign bus.ras_err   = ras_err_s;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model.
module tb_pc_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_err;

  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(32), .OFF_W(8)) bus ();

  pc_unit #(
    .ADDR_W       (32),
    .OFF_W        (8),
    .INSTR_BYTES  (4),
    .RESET_VECTOR (32'h0000_0000),
    .RAS_DEPTH    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic br, input logic jp, input logic cl,
                            input logic rt, input logic [7:0] off, input logic [31:0] tgt);
    int o;
    if (!st) begin
      if (rt) begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc = m_pc + 32'd4;
          m_err = 1'b1;
        end
      end else if (cl) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
        m_pc = tgt;
      end else if (jp) begin
        m_pc = tgt;
      end else if (br) begin
        o = int'($signed(off));
        m_pc = m_pc + 32'(4 + 4 * o);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: drive at negedge, sample 1ns after posedge, then park with stall.
  task automatic cycle(input logic st, input logic br, input logic jp, input logic cl,
                       input logic rt, input logic [7:0] off, input logic [31:0] tgt);
    @(negedge clk);
    bus.stall = st; bus.branch = br; bus.jump = jp; bus.call = cl; bus.ret = rt;
    bus.offset = off; bus.target = tgt;
    @(posedge clk);
    #1;
    model_step(st, br, jp, cl, rt, off, tgt);
    bus.stall = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.stall = 1'b1; bus.branch = 1'b0; bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.offset = 8'h00; bus.target = 32'h0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.pcout !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pcout, 32'h0); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.ras_empty); end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h200 + 32'(i * 16));
    // Asynchronous reset, asserted away from any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.pcout !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h want %h", bus.pcout, 32'h0); end
    checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got empty=%b full=%b want 1/0", bus.ras_empty, bus.ras_full); end
    checks++; if (bus.ras_err !== 1'b0) begin errors++; $display("FAIL async_reset_err: got %b want 0", bus.ras_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [6];
    exp_pc = '{32'd4, 32'd8, 32'd12, 32'd12, 32'd16, 32'd20};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cycle((i == 3), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      checks++; if (bus.pcout !== exp_pc[i] || bus.pcout !== m_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pcout, exp_pc[i]); end
      checks++; if (bus.pcnext !== exp_pc[i] + 32'd4) begin errors++; $display("FAIL seq_pcnext[%0d]: got %h want %h", i, bus.pcnext, exp_pc[i] + 32'd4); end
    end
  endtask

  task automatic test_branch();
    apply_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 32'h0);
    checks++; if (bus.pcout !== 32'h1C) begin errors++; $display("FAIL branch_neg: got %h want %h", bus.pcout, 32'h1C); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 32'h0);
    checks++; if (bus.pcout !== 32'h30) begin errors++; $display("FAIL branch_pos: got %h want %h", bus.pcout, 32'h30); end
  endtask

  task automatic test_call_ret();
    apply_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h10);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h100);
    checks++; if (bus.pcout !== 32'h100) begin errors++; $display("FAIL call_pc: got %h want %h", bus.pcout, 32'h100); end
    checks++; if (bus.ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty: got %b want 0", bus.ras_empty); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
    checks++; if (bus.pcout !== 32'h14) begin errors++; $display("FAIL ret_pc: got %h want %h", bus.pcout, 32'h14); end
    checks++; if (bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b0) begin errors++; $display("FAIL ret_flags: got empty=%b err=%b want 1/0", bus.ras_empty, bus.ras_err); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h1000 * 32'(i + 1));
    checks++; if (bus.ras_full !== 1'b1 || bus.ras_err !== 1'b1) begin errors++; $display("FAIL ovf_flags: got full=%b err=%b want 1/1", bus.ras_full, bus.ras_err); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
      checks++; if (bus.pcout !== m_pc || bus.pcout !== 32'h1000 * 32'(4 - i) + 32'd4) begin errors++; $display("FAIL ovf_ret[%0d]: got %h want %h", i, bus.pcout, 32'h1000 * 32'(4 - i) + 32'd4); end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
    checks++; if (bus.pcout !== 32'h1008) begin errors++; $display("FAIL underflow_pc: got %h want %h", bus.pcout, 32'h1008); end
    checks++; if (bus.ras_err !== 1'b1 || bus.ras_empty !== 1'b1) begin errors++; $display("FAIL underflow_flags: got err=%b empty=%b want 1/1", bus.ras_err, bus.ras_empty); end
  endtask

  task automatic test_wrap_priority();
    apply_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'hFFFF_FFFC);
    checks++; if (bus.pcnext !== 32'h0) begin errors++; $display("FAIL wrap_pcnext: got %h want %h", bus.pcnext, 32'h0); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    checks++; if (bus.pcout !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", bus.pcout, 32'h0); end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0000_0ABC);
    checks++; if (bus.pcout !== 32'h0ABC) begin errors++; $display("FAIL jump_over_branch: got %h want %h", bus.pcout, 32'h0ABC); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_0500);
    checks++; if (bus.pcout !== 32'h0AC0 || bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b1) begin errors++; $display("FAIL call_ret_pop_only: got pc=%h empty=%b err=%b want 0ac0/1/1", bus.pcout, bus.ras_empty, bus.ras_err); end
  endtask

  task automatic test_random();
    logic st, br, jp, cl, rt;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 7) == 0);
      rt = ($urandom_range(0, 4) == 0);
      cl = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 2) == 0);
      cycle(st, br, jp, cl, rt, 8'($urandom), $urandom);
      checks++;
      if (bus.pcout !== m_pc || bus.pcnext !== m_pc + 32'd4 ||
          bus.ras_empty !== (m_ras.size() == 0) || bus.ras_full !== (m_ras.size() == 4) ||
          bus.ras_err !== m_err) begin
        errors++;
        $display("FAIL random[%0d]: got pc=%h nx=%h e=%b f=%b err=%b want pc=%h nx=%h e=%b f=%b err=%b",
                 i, bus.pcout, bus.pcnext, bus.ras_empty, bus.ras_full, bus.ras_err,
                 m_pc, m_pc + 32'd4, (m_ras.size() == 0), (m_ras.size() == 4), m_err);
      end
    end
  endtask

  initial begin
    bus.stall = 1'b1; bus.branch = 1'b0; bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.offset = 8'h00; bus.target = 32'h0;
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_call_ret();
    test_overflow();
    test_wrap_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
